// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and data access.
//
// Data requests win arbitration by default. A starvation counter forces an
// instruction grant once STARVE_MAX data grants have been made while an
// instruction fetch is waiting. A granted RAM access always runs to completion.
// After each access the arbiter spends one turnaround cycle in IDLE, which gives
// the requester an edge to drop its request.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   iren/iaddr          instruction read request and address
//   iload/ihit          instruction word and completion pulse
//   dren/dwen           data read / write request (write wins if both are high)
//   daddr/dstore        data address and write data
//   dload/dhit          read data and completion pulse
//   ramREN/ramWEN       RAM read / write enables, never high together
//   ramaddr/ramstore    RAM address and write data, driven from registers
//   ramload/ramready    RAM read data, and completion of the current access
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [WORD_W-1:0] iload,
  output logic              ihit,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic [WORD_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ramready
);

  // The counter is at least 3 bits wide, and wider if STARVE_MAX needs it.
  localparam int CNT_W_MIN = $clog2(STARVE_MAX + 1);
  localparam int CNT_W     = (CNT_W_MIN > 3) ? CNT_W_MIN : 3;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              dreq;
  logic              data_win;

  assign dreq = dren | dwen;

  // The data port wins unless an instruction fetch is waiting and the data port
  // has already used its allowance of consecutive grants.
  assign data_win = dreq && ((starve_q < STARVE_LIM) || !iren);

  // State register, latched grant address/data and starvation counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      starve_q <= starve_d;
    end
  end

  // Next-state logic. Arbitration only happens in IDLE, so every access is
  // followed by a single turnaround cycle before the next grant.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    starve_d = starve_q;
    unique case (state_q)
      IDLE: begin
        if (data_win) begin
          state_d = dwen ? DWRITE : DREAD;
          addr_d  = daddr;
          store_d = dstore;
          if (!iren) begin
            starve_d = '0;
          end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (iren) begin
          state_d  = IFETCH;
          addr_d   = iaddr;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      IFETCH, DREAD, DWRITE: begin
        // A withdrawn request does not abort the access, because the RAM is
        // already committed to it.
        if (ramready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side. These outputs depend only on registers, never on requester inputs.
  always_comb begin
    ramREN   = (state_q == IFETCH) || (state_q == DREAD);
    ramWEN   = (state_q == DWRITE);
    ramaddr  = (state_q != IDLE) ? addr_q : '0;
    ramstore = (state_q == DWRITE) ? store_q : '0;
  end

  // Requester side. A hit is suppressed if the owning request was withdrawn.
  always_comb begin
    ihit  = (state_q == IFETCH) && ramready && iren;
    dhit  = ((state_q == DREAD)  && ramready && dren) ||
            ((state_q == DWRITE) && ramready && dwen);
    iload = ihit ? ramload : '0;
    dload = (dhit && (state_q == DREAD)) ? ramload : '0;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported main memory between the instruction-fetch port and the data port of the pipelined processor. It sits between the datapath/request unit (which produce `iren`, `dmemren` and `dmemwen`) and the RAM, and returns `ihit` and `dhit` to the pipeline. Data accesses win by default. A starvation counter forces an instruction grant after a bounded run of data grants. Every granted RAM transaction runs to completion, even if the requester withdraws.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `WORD_W`, default 32: data word width.
- `STARVE_MAX`, default 4: maximum number of consecutive data grants while an instruction request is pending.

Ports:
- `CLK`, in, 1: single clock; all state changes on its rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `iren`, in, 1: instruction read request; held until `ihit`.
- `iaddr`, in, ADDR_W: instruction address.
- `iload`, out, WORD_W: instruction word; valid while `ihit`.
- `ihit`, out, 1: instruction access complete (one-cycle pulse).
- `dren`, in, 1: data read request (from `dmemren`); held until `dhit`.
- `dwen`, in, 1: data write request (from `dmemwen`); held until `dhit`.
- `daddr`, in, ADDR_W: data address.
- `dstore`, in, WORD_W: write data.
- `dload`, out, WORD_W: read data; valid while `dhit` on a read.
- `dhit`, out, 1: data access complete (one-cycle pulse).
- `ramREN`, out, 1: RAM read enable.
- `ramWEN`, out, 1: RAM write enable.
- `ramaddr`, out, ADDR_W: RAM address.
- `ramstore`, out, WORD_W: RAM write data.
- `ramload`, in, WORD_W: RAM read data.
- `ramready`, in, 1: RAM completes the current access this cycle.

## Operation
- FSM states: IDLE, IFETCH, DREAD, DWRITE.
- IDLE arbitration, evaluated each cycle:
  - If the data port is requesting and `starve_cnt < STARVE_MAX` or `iren`=0: go to DWRITE if `dwen`, else DREAD.
  - Otherwise, if `iren`: go to IFETCH.
  - Otherwise: stay in IDLE.
- If `dren` and `dwen` are both high, the access is a write.
- Granted address and store data are latched into registers on the grant edge. RAM outputs are driven only from those registers and the state, so they are glitch-free and independent of the requester inputs.
- IFETCH: `ramREN`=1, `ramaddr`=latched iaddr.
- DREAD: `ramREN`=1, `ramaddr`=latched daddr.
- DWRITE: `ramWEN`=1, `ramaddr`=latched daddr, `ramstore`=latched dstore.
- `ramREN` and `ramWEN` are never high together, and both are 0 in IDLE.
- In a grant state with `ramready`=1:
  - Pulse the matching hit combinationally in the same cycle.
  - `iload`/`dload` = `ramload` passthrough.
  - Next state is IDLE.
- Completion always passes through IDLE for one turnaround cycle. This gives the requester one edge to drop its request, so no access is issued twice.
- Withdrawal: if the owning request deasserts during a grant, the RAM access still completes. The hit is suppressed at completion if the request is low in that cycle.
- `starve_cnt` is 3 bits wide, or wider as needed for `STARVE_MAX`:
  - It increments on each data grant made while `iren`=1.
  - It clears on an instruction grant, or on any IDLE cycle with `iren`=0.
  - It saturates at `STARVE_MAX`.
- `iload` and `dload` are 0 when their hit is low.

## Timing
- Reset: state=IDLE, `starve_cnt`=0, latched address and data registers=0.
- Reset values of outputs: `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0, `ihit`=`dhit`=0, `iload`=`dload`=0.
- RST asserted mid-transaction: the FSM returns to IDLE at that edge, no hit is issued, and the RAM enables drop in the next cycle.
- Minimum latency is 2 cycles: request seen in IDLE in cycle 0, RAM enable in cycle 1, hit in cycle 1 if `ramready`.
- With a RAM wait of W cycles, the hit arrives in cycle 1+W.
- Minimum spacing between grant edges is 2 cycles (access cycle plus IDLE turnaround).
- Worst-case instruction wait with continuous data traffic is STARVE_MAX data accesses followed by the instruction access.

## Test plan
1. Reset, then `iren`=1, `iaddr`=0x40, `ramready`=1 always, `ramload`=0x8C010004:
   - cycle 1: `ramREN`=1, `ramaddr`=0x40;
   - same cycle: `ihit`=1, `iload`=0x8C010004;
   - cycle 2: IDLE with all enables 0.
2. `iren` and `dren` raised together, `daddr`=0x100:
   - the data read is granted first and `dhit` pulses;
   - IDLE turnaround follows;
   - the IFETCH is granted next;
   - `ihit` is never high in the same cycle as `dhit`.
3. `dwen`=`dren`=1, `dstore`=0xDEADBEEF, `ramready` low for 3 cycles:
   - `ramWEN`=1 and `ramREN`=0 for 4 cycles;
   - `ramstore`=0xDEADBEEF;
   - `dhit` pulses on the 4th cycle.
4. `STARVE_MAX`=4, data requests held continuously, `iren`=1:
   - exactly 4 data grants occur, then one IFETCH grant;
   - `starve_cnt` returns to 0 after the IFETCH grant.
5. DREAD granted, `dren` dropped with `ramready` low, then `ramready`=1:
   - `ramREN` stays high until completion;
   - `dhit` stays 0;
   - the FSM returns to IDLE.
6. RST pulsed during DWRITE wait:
   - next cycle `ramWEN`=0 and state=IDLE;
   - no `dhit`;
   - a fresh request is granted normally afterwards.
